// File: rtl/modport_fifo_pkg.sv
// Shared defaults and types for the modport_fifo slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package modport_fifo_pkg;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 12;
  localparam int AE_LVL = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/modport_fifo_mem.sv
// Storage array for modport_fifo: DEPTH x DATA_W registers, one write port, one async read port.
// Latency: write lands at the clock edge; read data is combinational from raddr.
// Backpressure: none; the owner decides when writes are legal.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (async read port). Contents are never reset.
module modport_fifo_mem #(
  parameter int DATA_W = modport_fifo_pkg::DATA_W,
  parameter int DEPTH  = modport_fifo_pkg::DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO with full/empty and almost-full/almost-empty watermarks.
// Latency: o_rddata is registered, valid one edge after an accepted read; flags follow count combinationally.
// Backpressure: writes while full are dropped, reads while empty are ignored (o_rddata holds).
// Ports: clk, rstn (async, active-high), i_wren/i_wrdata (write side), i_rden/o_rddata (read side),
//        o_full, o_empty, o_alm_full, o_alm_empty (status).
// Build option MODPORT_FIFO_ERR_FLAGS_EN adds o_ovf/o_udf: one-cycle registered pulses after a
// dropped write or an ignored read.
module modport_fifo #(
  parameter int DATA_W = modport_fifo_pkg::DATA_W,
  parameter int DEPTH  = modport_fifo_pkg::DEPTH,
  parameter int AF_LVL = modport_fifo_pkg::AF_LVL,
  parameter int AE_LVL = modport_fifo_pkg::AE_LVL
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic              i_rden,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [DATA_W-1:0] o_rddata
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
  ,
  output logic              o_ovf,
  output logic              o_udf
`endif
);
  import modport_fifo_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_ok;
  logic              rd_ok;

  // A write while full is dropped even when a read frees a slot on the same edge.
  assign wr_ok = i_wren & ~o_full;
  assign rd_ok = i_rden & ~o_empty;

  modport_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (i_wrdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by natural overflow.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_rddata <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + PW'(1);
        o_rddata <= mem_rdata;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_full      = (count == CW'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= CW'(AF_LVL));
  assign o_alm_empty = (count <= CW'(AE_LVL));

`ifdef MODPORT_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      o_ovf <= i_wren & o_full;
      o_udf <= i_rden & o_empty;
    end
  end
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// Directed and randomized bench for modport_fifo against a queue-based reference model.
module tb_modport_fifo;
  import modport_fifo_pkg::*;

  logic  clk;
  logic  rstn;
  logic  i_wren;
  logic  i_rden;
  data_t i_wrdata;
  logic  o_full;
  logic  o_empty;
  logic  o_alm_full;
  logic  o_alm_empty;
  data_t o_rddata;
  logic  o_ovf;
  logic  o_udf;

  int    checks   = 0;
  int    failures = 0;

  data_t q[$];
  data_t exp_rd;
  logic  exp_ovf;
  logic  exp_udf;

  modport_fifo dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_wrdata    (i_wrdata),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata)
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    ,
    .o_ovf       (o_ovf),
    .o_udf       (o_udf)
`endif
  );

`ifndef MODPORT_FIFO_ERR_FLAGS_EN
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".full"},      128'(o_full),      128'(n == DEPTH));
    chk({tag, ".empty"},     128'(o_empty),     128'(n == 0));
    chk({tag, ".alm_full"},  128'(o_alm_full),  128'(n >= AF_LVL));
    chk({tag, ".alm_empty"}, 128'(o_alm_empty), 128'(n <= AE_LVL));
    chk({tag, ".rddata"},    o_rddata,          exp_rd);
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"},       128'(o_ovf),       128'(exp_ovf));
    chk({tag, ".udf"},       128'(o_udf),       128'(exp_udf));
`endif
  endtask

  function automatic data_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive, let the edge happen, advance the model from pre-edge occupancy, then check.
  task automatic step(input string tag, input logic we, input logic re, input data_t d);
    int sz;
    i_wren   = we;
    i_rden   = re;
    i_wrdata = d;
    @(posedge clk);
    sz      = q.size();
    exp_ovf = we && (sz == DEPTH);
    exp_udf = re && (sz == 0);
    if (re && sz != 0) exp_rd = q.pop_front();
    if (we && sz != DEPTH) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  initial begin
    rstn     = 1'b1;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
    model_reset();

    // Power-on reset.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    #2 rstn = 1'b0;

    // Mid-traffic asynchronous reset, asserted between edges.
    for (int i = 0; i < 3; i++) step("pre_rst_wr", 1'b1, 1'b0, rnd128());
    step("pre_rst_rd", 1'b1, 1'b1, rnd128());
    #2 rstn = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    #2 rstn = 1'b0;
    i_wren = 1'b0;
    i_rden = 1'b0;

    // Fill with 1..16, then one dropped write while full.
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, data_t'(i));
    chk("fill.full_at_16", 128'(o_full), 128'(1));
    step("fill_ovf", 1'b1, 1'b0, data_t'(32'hDEAD));
    step("fill_idle", 1'b0, 1'b0, '0);

    // Drain 16 entries in order, then a read while empty that must leave o_rddata at 0x10.
    for (int i = 1; i <= 16; i++) step("drain", 1'b0, 1'b1, '0);
    chk("drain.last_data", o_rddata, data_t'(16));
    step("drain_udf", 1'b0, 1'b1, '0);
    chk("drain.hold_data", o_rddata, data_t'(16));
    step("drain_idle", 1'b0, 1'b0, '0);

    // Simultaneous read+write at count 5.
    for (int i = 0; i < 5; i++) step("sim_fill", 1'b1, 1'b0, rnd128());
    for (int i = 0; i < 10; i++) step("sim_rw", 1'b1, 1'b1, rnd128());
    chk("sim.count5", 128'(q.size()), 128'(5));
    for (int i = 0; i < 5; i++) step("sim_drain", 1'b0, 1'b1, '0);

    // Randomized interleaving with 128-bit data across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd128());
    end
    for (int i = 0; i < 80; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), rnd128());
    end

    // Full and read+write together: read accepted, write dropped.
    while (q.size() < DEPTH) step("top_up", 1'b1, 1'b0, rnd128());
    step("full_rw", 1'b1, 1'b1, rnd128());
    chk("full_rw.not_full", 128'(o_full), 128'(0));
    chk("full_rw.depth15", 128'(q.size()), 128'(15));
    while (q.size() > 0) step("final_drain", 1'b0, 1'b1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
